// File: rtl/radiometer_pkg.sv
`default_nettype none
// ============================================================================
// Package : radiometer_pkg
// Purpose : Types, constants and the saturating-add helper used by the
//           Dicke switch demodulator.
// Revision: 1.0 - initial release
// ============================================================================
package radiometer_pkg;

  // Demodulation phase as carried by the demod reference.
  typedef enum logic {
    PH_REF = 1'b0,
    PH_ANT = 1'b1
  } phase_e;

  // Default system clock rate.
  localparam int unsigned CLK_HZ = 100_000_000;

  // Working width of sat_add. Callers zero-extend operands and limit to it.
  localparam int SAT_W = 64;

  // Saturating add: returns {overflow, sum}, with sum clamped to lim.
  function automatic logic [SAT_W:0] sat_add(
    input logic [SAT_W-1:0] a,
    input logic [SAT_W-1:0] b,
    input logic [SAT_W-1:0] lim
  );
    logic [SAT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, lim}) begin
      sat_add = {1'b1, lim};
    end else begin
      sat_add = {1'b0, s[SAT_W-1:0]};
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/switch_phase_gen.sv
`default_nettype none
// ============================================================================
// Module  : switch_phase_gen
// Purpose : Dicke switch timing. Produces the switch drive, the lagged
//           demod reference, the post-edge blanking window and a strobe on
//           every demod 0->1 edge that closes a switch period.
// Ports   : clk        in  system clock
//           clr_n      in  asynchronous active-low reset
//           enable     in  run; low parks the switch on the reference
//           switch_pwm out switch drive, 1 = antenna
//           demod      out switch_pwm delayed DEMOD_LAG cycles
//           blank      out samples must be discarded
//           period_end out demod rising edge (not the first after enable)
// Revision: 1.0 - initial release
// ============================================================================
module switch_phase_gen #(
  parameter int HALF_PERIOD  = 50000,
  parameter int DEMOD_LAG    = 0,
  parameter int BLANK_CYCLES = 5000
) (
  input  logic clk,
  input  logic clr_n,
  input  logic enable,
  output logic switch_pwm,
  output logic demod,
  output logic blank,
  output logic period_end
);

  localparam int PH_W = $clog2(HALF_PERIOD);
  localparam int BL_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam logic [PH_W-1:0] c_PH_LAST = PH_W'(HALF_PERIOD - 1);
  localparam logic [BL_W-1:0] c_BLANK_LOAD =
    (BLANK_CYCLES > 0) ? BL_W'(BLANK_CYCLES - 1) : '0;
  localparam logic c_HAS_BLANK = (BLANK_CYCLES > 0);

  logic [PH_W-1:0] r_ph_cnt;
  logic            r_pwm;
  logic            r_run;
  logic            r_demod_d;
  logic            r_armed;
  logic [BL_W-1:0] r_blank_cnt;
  logic            r_live;
  logic            w_demod;
  logic            w_edge;

  // Phase counter and switch drive. The first enabled clock starts the
  // antenna half; each half lasts HALF_PERIOD clocks.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_ph_cnt <= '0;
      r_pwm    <= 1'b0;
      r_run    <= 1'b0;
      r_live   <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (!enable) begin
        r_run    <= 1'b0;
        r_ph_cnt <= '0;
        r_pwm    <= 1'b0;
      end else if (!r_run) begin
        r_run    <= 1'b1;
        r_ph_cnt <= '0;
        r_pwm    <= 1'b1;
      end else if (r_ph_cnt == c_PH_LAST) begin
        r_ph_cnt <= '0;
        r_pwm    <= ~r_pwm;
      end else begin
        r_ph_cnt <= r_ph_cnt + 1'b1;
      end
    end
  end

  // Lag line models front-end plus ADC latency.
  if (DEMOD_LAG == 0) begin : g_no_lag
    assign w_demod = r_pwm;
  end else begin : g_lag
    logic [DEMOD_LAG-1:0] r_lag;
    always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
        r_lag <= '0;
      end else if (!enable) begin
        r_lag <= '0;
      end else begin
        r_lag[0] <= r_pwm;
        for (int i = 1; i < DEMOD_LAG; i++) begin
          r_lag[i] <= r_lag[i-1];
        end
      end
    end
    assign w_demod = r_lag[DEMOD_LAG-1];
  end

  assign w_edge = w_demod ^ r_demod_d;

  // Edge tracking and blank window. r_armed marks that the demod reference
  // has made its first edge since enable.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_demod_d   <= 1'b0;
      r_armed     <= 1'b0;
      r_blank_cnt <= '0;
    end else if (!enable) begin
      r_demod_d   <= 1'b0;
      r_armed     <= 1'b0;
      r_blank_cnt <= '0;
    end else begin
      r_demod_d <= w_demod;
      if (w_edge) begin
        r_armed     <= 1'b1;
        r_blank_cnt <= c_BLANK_LOAD;
      end else if (r_blank_cnt != '0) begin
        r_blank_cnt <= r_blank_cnt - 1'b1;
      end
    end
  end

  assign switch_pwm = r_pwm;
  assign demod      = w_demod;
  // r_live holds blank low while in reset.
  assign blank      = r_live & (~enable | ~r_armed |
                      (c_HAS_BLANK & (w_edge | (r_blank_cnt != '0))));
  assign period_end = enable & r_armed & w_demod & ~r_demod_d;

endmodule
`default_nettype wire

// File: rtl/dicke_switch_demod.sv
`default_nettype none
// ============================================================================
// Module  : dicke_switch_demod
// Purpose : Dicke switch generator and synchronous demodulator. Accumulates
//           ADC samples into antenna/reference sums over INTEG_PERIODS
//           switch periods and latches the results.
// Ports   : clk, clr_n (async active-low), enable, adc_data, adc_valid
//           switch_pwm, demod, blank       switch timing
//           ant_sum, ref_sum, ant_cnt, ref_cnt, overflow  latched results
//           result_valid                   one-cycle pulse on result update
// Revision: 1.0 - initial release
// ============================================================================
module dicke_switch_demod
  import radiometer_pkg::*;
#(
  parameter int HALF_PERIOD   = 50000,
  parameter int DEMOD_LAG     = 0,
  parameter int BLANK_CYCLES  = 5000,
  parameter int INTEG_PERIODS = 100,
  parameter int ADC_W         = 12,
  parameter int ACC_W         = 32,
  parameter int CNT_W         = 24
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             enable,
  input  logic [ADC_W-1:0] adc_data,
  input  logic             adc_valid,
  output logic             switch_pwm,
  output logic             demod,
  output logic             blank,
  output logic [ACC_W-1:0] ant_sum,
  output logic [ACC_W-1:0] ref_sum,
  output logic [CNT_W-1:0] ant_cnt,
  output logic [CNT_W-1:0] ref_cnt,
  output logic             result_valid,
  output logic             overflow
);

  localparam int PC_W = $clog2(INTEG_PERIODS + 1);
  localparam logic [PC_W-1:0]  c_PC_LAST = PC_W'(INTEG_PERIODS - 1);
  localparam logic [SAT_W-1:0] c_ACC_MAX = (SAT_W'(1) << ACC_W) - SAT_W'(1);
  localparam logic [SAT_W-1:0] c_CNT_MAX = (SAT_W'(1) << CNT_W) - SAT_W'(1);

  logic             w_period_end;
  logic             w_accept;
  phase_e           w_phase;
  logic [ACC_W-1:0] w_sum_cur;
  logic [CNT_W-1:0] w_cnt_cur;
  logic [SAT_W:0]   w_sum_add;
  logic [SAT_W:0]   w_cnt_add;
  logic             w_sum_ovf;
  logic             w_cnt_ovf;
  logic [ACC_W-1:0] w_sum_new;
  logic [CNT_W-1:0] w_cnt_new;

  logic [ACC_W-1:0] r_ant_acc, r_ref_acc;
  logic [CNT_W-1:0] r_ant_n, r_ref_n;
  logic             r_ovf;
  logic [PC_W-1:0]  r_per_cnt;
  logic [ACC_W-1:0] r_ant_sum_q, r_ref_sum_q;
  logic [CNT_W-1:0] r_ant_cnt_q, r_ref_cnt_q;
  logic             r_ovf_q;
  logic             r_rv;

  switch_phase_gen #(
    .HALF_PERIOD (HALF_PERIOD),
    .DEMOD_LAG   (DEMOD_LAG),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_phase (
    .clk       (clk),
    .clr_n     (clr_n),
    .enable    (enable),
    .switch_pwm(switch_pwm),
    .demod     (demod),
    .blank     (blank),
    .period_end(w_period_end)
  );

  assign w_phase  = phase_e'(demod);
  assign w_accept = adc_valid & ~blank & enable;

  // Only one phase accumulates per cycle, so one saturating adder pair
  // serves both accumulators.
  assign w_sum_cur = (w_phase == PH_ANT) ? r_ant_acc : r_ref_acc;
  assign w_cnt_cur = (w_phase == PH_ANT) ? r_ant_n   : r_ref_n;
  assign w_sum_add = sat_add(SAT_W'(w_sum_cur), SAT_W'(adc_data), c_ACC_MAX);
  assign w_cnt_add = sat_add(SAT_W'(w_cnt_cur), SAT_W'(1), c_CNT_MAX);
  // Bits above the target width are zero after clamping; folding them in
  // keeps the whole adder result meaningful.
  assign w_sum_ovf = w_sum_add[SAT_W] | (|(w_sum_add[SAT_W-1:0] & ~c_ACC_MAX));
  assign w_cnt_ovf = w_cnt_add[SAT_W] | (|(w_cnt_add[SAT_W-1:0] & ~c_CNT_MAX));
  assign w_sum_new = w_sum_add[ACC_W-1:0];
  assign w_cnt_new = w_cnt_add[CNT_W-1:0];

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_ant_acc   <= '0;
      r_ref_acc   <= '0;
      r_ant_n     <= '0;
      r_ref_n     <= '0;
      r_ovf       <= 1'b0;
      r_per_cnt   <= '0;
      r_ant_sum_q <= '0;
      r_ref_sum_q <= '0;
      r_ant_cnt_q <= '0;
      r_ref_cnt_q <= '0;
      r_ovf_q     <= 1'b0;
      r_rv        <= 1'b0;
    end else begin
      r_rv <= 1'b0;
      if (!enable) begin
        // Partial integration is dropped; latched results are kept.
        r_ant_acc <= '0;
        r_ref_acc <= '0;
        r_ant_n   <= '0;
        r_ref_n   <= '0;
        r_ovf     <= 1'b0;
        r_per_cnt <= '0;
      end else if (w_period_end && (r_per_cnt == c_PC_LAST)) begin
        r_ant_sum_q <= r_ant_acc;
        r_ref_sum_q <= r_ref_acc;
        r_ant_cnt_q <= r_ant_n;
        r_ref_cnt_q <= r_ref_n;
        r_ovf_q     <= r_ovf;
        r_rv        <= 1'b1;
        r_ant_acc   <= '0;
        r_ref_acc   <= '0;
        r_ant_n     <= '0;
        r_ref_n     <= '0;
        r_ovf       <= 1'b0;
        r_per_cnt   <= '0;
      end else begin
        if (w_period_end) begin
          r_per_cnt <= r_per_cnt + 1'b1;
        end
        if (w_accept) begin
          if (w_phase == PH_ANT) begin
            r_ant_acc <= w_sum_new;
            r_ant_n   <= w_cnt_new;
          end else begin
            r_ref_acc <= w_sum_new;
            r_ref_n   <= w_cnt_new;
          end
          r_ovf <= r_ovf | w_sum_ovf | w_cnt_ovf;
        end
      end
    end
  end

  assign ant_sum      = r_ant_sum_q;
  assign ref_sum      = r_ref_sum_q;
  assign ant_cnt      = r_ant_cnt_q;
  assign ref_cnt      = r_ref_cnt_q;
  assign overflow     = r_ovf_q;
  assign result_valid = r_rv;

endmodule
`default_nettype wire

// File: tb/tb_dicke_switch_demod.sv
`default_nettype none
// ============================================================================
// Module  : tb_dicke_switch_demod
// Purpose : Self-checking bench. Instance A: HALF=10, LAG=0, BLANK=2,
//           INTEG=2. Instance B: HALF=10, LAG=3, BLANK=2, INTEG=1, ACC_W=8.
// Revision: 1.0 - initial release
// ============================================================================
module tb_dicke_switch_demod;

  localparam int HALF = 10;

  typedef struct {
    logic [31:0] ant_sum;
    logic [31:0] ref_sum;
    logic [31:0] ant_cnt;
    logic [31:0] ref_cnt;
    logic [31:0] ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        clr_n = 1'b0;
  logic        ena_a = 1'b0, ena_b = 1'b0;
  logic [11:0] data_a = '0, data_b = '0;
  logic        valid = 1'b1;

  logic        pwm_a, demod_a, blank_a, rv_a, ovf_a;
  logic [31:0] ant_sum_a, ref_sum_a;
  logic [23:0] ant_cnt_a, ref_cnt_a;
  logic        pwm_b, demod_b, blank_b, rv_b, ovf_b;
  logic [7:0]  ant_sum_b, ref_sum_b;
  logic [23:0] ant_cnt_b, ref_cnt_b;

  int checks = 0;
  int errors = 0;
  res_t qa[$];
  res_t qb[$];

  always #5 clk = ~clk;

  dicke_switch_demod #(
    .HALF_PERIOD(HALF), .DEMOD_LAG(0), .BLANK_CYCLES(2), .INTEG_PERIODS(2),
    .ADC_W(12), .ACC_W(32), .CNT_W(24)
  ) dut_a (
    .clk(clk), .clr_n(clr_n), .enable(ena_a), .adc_data(data_a),
    .adc_valid(valid), .switch_pwm(pwm_a), .demod(demod_a), .blank(blank_a),
    .ant_sum(ant_sum_a), .ref_sum(ref_sum_a), .ant_cnt(ant_cnt_a),
    .ref_cnt(ref_cnt_a), .result_valid(rv_a), .overflow(ovf_a)
  );

  dicke_switch_demod #(
    .HALF_PERIOD(HALF), .DEMOD_LAG(3), .BLANK_CYCLES(2), .INTEG_PERIODS(1),
    .ADC_W(12), .ACC_W(8), .CNT_W(24)
  ) dut_b (
    .clk(clk), .clr_n(clr_n), .enable(ena_b), .adc_data(data_b),
    .adc_valid(valid), .switch_pwm(pwm_b), .demod(demod_b), .blank(blank_b),
    .ant_sum(ant_sum_b), .ref_sum(ref_sum_b), .ant_cnt(ant_cnt_b),
    .ref_cnt(ref_cnt_b), .result_valid(rv_b), .overflow(ovf_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Antenna half in cycle j after enable (antenna half first).
  function automatic logic ant_ph(input int j);
    return ((j / HALF) % 2) == 0;
  endfunction

  // Scoreboard: results are compared whenever a DUT pulses result_valid.
  always @(negedge clk) begin : mon
    res_t e;
    if (rv_a) begin
      checks++;
      assert (qa.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_result_a observed=1 expected=0");
      end
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("a_ant_sum", ant_sum_a, e.ant_sum);
        chk("a_ref_sum", ref_sum_a, e.ref_sum);
        chk("a_ant_cnt", 32'(ant_cnt_a), e.ant_cnt);
        chk("a_ref_cnt", 32'(ref_cnt_a), e.ref_cnt);
        chk("a_ovf", 32'(ovf_a), e.ovf);
      end
    end
    if (rv_b) begin
      checks++;
      assert (qb.size() > 0) else begin
        errors++;
        $error("FAIL unexpected_result_b observed=1 expected=0");
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("b_ant_sum", 32'(ant_sum_b), e.ant_sum);
        chk("b_ref_sum", 32'(ref_sum_b), e.ref_sum);
        chk("b_ant_cnt", 32'(ant_cnt_b), e.ant_cnt);
        chk("b_ref_cnt", 32'(ref_cnt_b), e.ref_cnt);
        chk("b_ovf", 32'(ovf_b), e.ovf);
      end
    end
  end

  // Run instance A for n cycles from enable, driving 100 in antenna halves
  // and 40 in reference halves; optionally checks switch timing.
  task automatic run_a(input int n, input bit chk_pwm);
    @(negedge clk);
    ena_a = 1'b1;
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (chk_pwm) begin
        chk("a_pwm", 32'(pwm_a), 32'(ant_ph(j)));
        chk("a_demod", 32'(demod_a), 32'(ant_ph(j)));
      end
      data_a = ant_ph(j) ? 12'd100 : 12'd40;
    end
    ena_a = 1'b0;
  endtask

  initial begin
    res_t r;
    // Reset state
    #1;
    chk("rst_pwm", 32'(pwm_a), 0);
    chk("rst_blank", 32'(blank_a), 0);
    chk("rst_ant_sum", ant_sum_a, 0);
    chk("rst_rv", 32'(rv_a), 0);
    @(negedge clk);
    clr_n = 1'b1;
    @(negedge clk);
    chk("idle_blank", 32'(blank_a), 1);
    chk("idle_pwm", 32'(pwm_a), 0);

    // Switch timing and two full integrations on A
    r = '{ant_sum: 1600, ref_sum: 640, ant_cnt: 16, ref_cnt: 16, ovf: 0};
    qa.push_back(r);
    qa.push_back(r);
    run_a(85, 1'b1);
    @(negedge clk);
    chk("a_hold_ant_sum", ant_sum_a, 1600);
    chk("a_hold_blank", 32'(blank_a), 1);

    // Partial run dropped, then a fresh full run
    run_a(30, 1'b0);
    repeat (3) @(negedge clk);
    chk("a_drop_ref_sum", ref_sum_a, 640);
    qa.push_back(r);
    run_a(45, 1'b0);
    repeat (2) @(negedge clk);

    // Lag, blank and saturation on B
    data_b = 12'd255;
    qb.push_back('{ant_sum: 255, ref_sum: 255, ant_cnt: 8, ref_cnt: 8, ovf: 1});
    qb.push_back('{ant_sum: 0, ref_sum: 0, ant_cnt: 8, ref_cnt: 8, ovf: 0});
    @(negedge clk);
    ena_b = 1'b1;
    for (int j = 0; j < 50; j++) begin
      @(negedge clk);
      if (j < 25) begin
        chk("b_pwm", 32'(pwm_b), 32'(ant_ph(j)));
        chk("b_demod", 32'(demod_b), (j < 3) ? 0 : 32'(ant_ph(j - 3)));
        chk("b_blank", 32'(blank_b), ((j < 3) || ((j - 3) % HALF) < 2) ? 1 : 0);
      end
      data_b = (j < 23) ? 12'd255 : 12'd0;
    end
    ena_b = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset mid-run, then restart
    run_a(25, 1'b0);
    ena_a = 1'b1;
    @(negedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("arst_ant_sum", ant_sum_a, 0);
    chk("arst_ref_cnt", 32'(ref_cnt_a), 0);
    chk("arst_pwm", 32'(pwm_a), 0);
    chk("arst_blank", 32'(blank_a), 0);
    chk("arst_b_ant_cnt", 32'(ant_cnt_b), 0);
    @(negedge clk);
    ena_a = 1'b0;
    clr_n = 1'b1;
    qa.push_back(r);
    run_a(45, 1'b1);
    repeat (3) @(negedge clk);

    chk("a_results_pending", 32'(qa.size()), 0);
    chk("b_results_pending", 32'(qb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
